// File: rtl/uart_cmd_pkg.sv
// Shared constants, parser state set and counter sizing for the UART command parser.
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_W    = 8'h57;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_W_LC = 8'h77;
    localparam logic [7:0] ASCII_R_LC = 8'h72;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPC     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_ASEP    = 3'd3,
        ST_DATA    = 3'd4,
        ST_TERM    = 3'd5,
        ST_DISCARD = 3'd6
    } state_e;

    // Counter must hold the longest field length, not just length-1.
    function automatic int cnt_width(input int addr_digits, input int data_digits);
        int m;
        m = (addr_digits > data_digits) ? addr_digits : data_digits;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/uart_hex_nibble.sv
// ASCII to hex nibble decoder; lowercase a-f accepted when UART_CMD_LOWER_HEX_EN is defined.
module uart_hex_nibble (
    input  logic [7:0] ch,
    output logic       vld,
    output logic [3:0] nib
);

    always_comb begin
        vld = 1'b0;
        nib = 4'h0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            vld = 1'b1;
            nib = ch[3:0];
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            vld = 1'b1;
            nib = ch[3:0] + 4'd9;
        end
`ifdef UART_CMD_LOWER_HEX_EN
        else if (ch >= 8'h61 && ch <= 8'h66) begin
            vld = 1'b1;
            nib = ch[3:0] + 4'd9;
        end
`endif
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles "W AA DDDD<CR>" / "R AA<CR>" hex lines into single-cycle register commands.
// Define UART_CMD_LOWER_HEX_EN to also accept lowercase opcodes and hex digits.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_DIGITS = 2,
    parameter int DATA_DIGITS = 4,
    localparam int ADDR_W = 4 * ADDR_DIGITS,
    localparam int DATA_W = 4 * DATA_DIGITS
) (
    input  logic              CLK_100M,
    input  logic              SYS_RST,
    input  logic              UART_RX_DVLD,
    input  logic [7:0]        UART_RX_DATA,
    output logic              CMD_VLD,
    output logic              CMD_WR,
    output logic [ADDR_W-1:0] CMD_ADDR,
    output logic [DATA_W-1:0] CMD_DATA,
    output logic              CMD_ERR,
    output logic              CMD_BUSY
);

    localparam int CNT_W = cnt_width(ADDR_DIGITS, DATA_DIGITS);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                vld_q, vld_d;
    logic                err_q, err_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_data_q, cmd_data_d;

    logic                nib_vld;
    logic [3:0]          nib;
    logic                is_sp, is_cr, is_term, is_wop, is_rop, bad;

    uart_hex_nibble u_hex (
        .ch  (UART_RX_DATA),
        .vld (nib_vld),
        .nib (nib)
    );

    always_comb begin
        is_sp   = (UART_RX_DATA == ASCII_SP);
        is_cr   = (UART_RX_DATA == ASCII_CR);
        is_term = is_cr || (UART_RX_DATA == ASCII_LF);
        is_wop  = (UART_RX_DATA == ASCII_W);
        is_rop  = (UART_RX_DATA == ASCII_R);
`ifdef UART_CMD_LOWER_HEX_EN
        is_wop  = is_wop || (UART_RX_DATA == ASCII_W_LC);
        is_rop  = is_rop || (UART_RX_DATA == ASCII_R_LC);
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        vld_d      = 1'b0;
        err_d      = 1'b0;
        wr_d       = wr_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        bad        = 1'b0;

        if (UART_RX_DVLD) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_wop || is_rop) begin
                        op_wr_d = is_wop;
                        state_d = ST_OPC;
                    end else if (!(is_sp || is_term)) begin
                        bad = 1'b1;
                    end
                end
                ST_OPC: begin
                    if (is_sp) begin
                        cnt_d   = '0;
                        addr_d  = '0;
                        state_d = ST_ADDR;
                    end else begin
                        bad = 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (nib_vld) begin
                        addr_d = (addr_q << 4) | ADDR_W'(nib);
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ADDR_DIGITS - 1))
                            state_d = op_wr_q ? ST_ASEP : ST_TERM;
                    end else begin
                        bad = 1'b1;
                    end
                end
                ST_ASEP: begin
                    if (is_sp) begin
                        cnt_d   = '0;
                        data_d  = '0;
                        state_d = ST_DATA;
                    end else begin
                        bad = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (nib_vld) begin
                        data_d = (data_q << 4) | DATA_W'(nib);
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_DIGITS - 1))
                            state_d = ST_TERM;
                    end else begin
                        bad = 1'b1;
                    end
                end
                ST_TERM: begin
                    if (is_cr) begin
                        vld_d      = 1'b1;
                        wr_d       = op_wr_q;
                        cmd_addr_d = addr_q;
                        cmd_data_d = op_wr_q ? data_q : '0;
                        state_d    = ST_IDLE;
                    end else begin
                        bad = 1'b1;
                    end
                end
                ST_DISCARD: begin
                    if (is_term)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            // A terminator that breaks the line also ends it, so no discard phase.
            if (bad) begin
                err_d   = 1'b1;
                state_d = is_term ? ST_IDLE : ST_DISCARD;
            end
        end
    end

    always_ff @(posedge CLK_100M or posedge SYS_RST) begin
        if (SYS_RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_wr_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
            wr_q       <= 1'b0;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_wr_q    <= op_wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
            wr_q       <= wr_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
        end
    end

    assign CMD_VLD  = vld_q;
    assign CMD_ERR  = err_q;
    assign CMD_WR   = wr_q;
    assign CMD_ADDR = cmd_addr_q;
    assign CMD_DATA = cmd_data_q;
    assign CMD_BUSY = (state_q != ST_IDLE);

endmodule
